range_stats: RTL
================

Name: range_stats

Overview:
- Parametrised successor to the single-channel range finder.
- Tracks minimum, maximum, range and sample count over a capture window bounded by go/finish.
- Adds a per-sample valid qualifier, a selectable signed/unsigned compare, a saturating sample counter, and registered results that are held until the next capture.
- Sits between a sample source (ADC/sensor front end) and host readout logic.

Parameters:
- WIDTH, 16, bit width of data_in, min_out, max_out and range_out.
- CNT_WIDTH, 8, bit width of the sample counter count_out.
- SIGNED, 0, 0 = unsigned compare and range; 1 = two's-complement compare (range is still reported unsigned).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  sample value.
- data_valid  input  1  data_in is a sample this cycle.
- go  input  1  start (or restart) a capture window.
- finish  input  1  close the current capture window.
- min_out  output  WIDTH  registered window minimum.
- max_out  output  WIDTH  registered window maximum.
- range_out  output  WIDTH  registered max_out - min_out.
- count_out  output  CNT_WIDTH  number of valid samples in the window, saturating.
- result_valid  output  1  results are final and stable.
- empty  output  1  the window closed with zero samples.
- cnt_sat  output  1  count_out saturated during this window (sticky).
- debug_error  output  1  protocol error (Moore output).

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - All outputs and internal min/max/count registers = 0.
- States are IDLE, ACTIVE, DONE and ERROR. Priority within a cycle is finish > go.
- IDLE:
  - finish -> ERROR.
  - else go -> ACTIVE, clearing count, empty, cnt_sat and result_valid.
- ACTIVE:
  - finish -> DONE.
  - else go -> ACTIVE (restart): count cleared, and the next valid sample re-seeds min/max.
- DONE:
  - result_valid = 1 in this state.
  - go -> ACTIVE.
  - finish -> ERROR.
  - otherwise hold DONE indefinitely.
- ERROR:
  - debug_error = 1 in this state; result_valid = 0.
  - go -> ACTIVE; otherwise stay.
- Sample accept:
  - A sample is accepted when in ACTIVE and data_valid = 1, including the cycle in which finish is asserted.
  - No sample is accepted in the go cycle itself.
  - First accepted sample (count = 0): min = max = data_in.
  - Later samples: update min if data_in < min and, independently, max if data_in > max. Both may update on the same sample.
  - Compare is signed when SIGNED = 1.
- Counter:
  - Increments per accepted sample.
  - At all-ones it holds and sets cnt_sat; cnt_sat stays set until the next go.
- Results on the ACTIVE->DONE transition (registered, valid the cycle after finish):
  - If count = 0 (after including any sample accepted that cycle): empty = 1, and min_out/max_out/range_out = 0.
  - Otherwise range_out = max - min computed modulo 2^WIDTH; this is exact as an unsigned magnitude for both modes.
- Output hold:
  - min_out/max_out/range_out/count_out are updated only on the ACTIVE->DONE transition.
  - They hold their last values through ACTIVE and ERROR, and are zeroed only by reset.
- Latency: finish at cycle N -> result_valid = 1 at cycle N+1.
- Reset mid-window: everything clears immediately and no result is produced.

Test Plan:
- Unsigned WIDTH=16: go; samples 50, 20, 90, 40 with data_valid; finish in the same cycle as 40 -> next cycle result_valid = 1, min = 20, max = 90, range = 70, count = 4.
- data_valid gating: go; data_in = 5 with valid = 0, then 30 and 60 with valid = 1; finish -> min = 30, max = 60, range = 30, count = 2. Also: samples 10 then 100 -> min and max both update, range = 90.
- SIGNED=1, WIDTH=8: samples -100 (0x9C) and 27 (0x1B) -> min = 0x9C, max = 0x1B, range = 127.
- Protocol errors:
  - finish in IDLE -> debug_error = 1 from the next cycle; go -> ACTIVE, debug_error = 0.
  - go + finish together in IDLE -> ERROR.
  - finish in DONE -> ERROR.
- Empty window and saturation:
  - go then finish with no valid samples -> empty = 1, range = 0.
  - CNT_WIDTH=4 with 20 samples -> count = 15, cnt_sat = 1.
  - Next go clears empty and cnt_sat.
- Restart and reset:
  - go mid-ACTIVE discards prior samples (old min = 1 is not kept).
  - reset_n low mid-window -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/range_stats_if.sv
// Sample/control and result bundle for range_stats.
// master drives samples and window control, slave returns results.
`timescale 1ns/1ps
interface range_stats_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
);
  logic [WIDTH-1:0]     data_in;
  logic                 data_valid;
  logic                 go;
  logic                 finish;
  logic [WIDTH-1:0]     min_out;
  logic [WIDTH-1:0]     max_out;
  logic [WIDTH-1:0]     range_out;
  logic [CNT_WIDTH-1:0] count_out;
  logic                 result_valid;
  logic                 empty;
  logic                 cnt_sat;
  logic                 debug_error;

  modport master (
    output data_in, data_valid, go, finish,
    input  min_out, max_out, range_out, count_out,
    input  result_valid, empty, cnt_sat, debug_error
  );

  modport slave (
    input  data_in, data_valid, go, finish,
    output min_out, max_out, range_out, count_out,
    output result_valid, empty, cnt_sat, debug_error
  );
endinterface

// File: rtl/range_stats.sv
// Windowed min/max/range/count tracker with go/finish framing.
// Results are captured on window close and held until the next close.
`timescale 1ns/1ps
module range_stats #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8,
  parameter bit SIGNED    = 1'b0
) (
  input  logic         clock,
  input  logic         reset_n,
  range_stats_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t st, nxt;

  logic [WIDTH-1:0]     min_r, max_r;
  logic [WIDTH-1:0]     min_n, max_n;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_n;
  logic [WIDTH-1:0]     min_o, max_o, rng_o;
  logic [CNT_WIDTH-1:0] cnt_o;
  logic                 empty_r, sat_r;
  logic                 start, accept, close, cnt_full;

  function automatic logic lt(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    if (SIGNED) return $signed(a) < $signed(b);
    else        return a < b;
  endfunction

  // finish outranks go in every state
  assign start    = bus.go && !bus.finish;
  assign close    = (st == S_ACTIVE) && bus.finish;
  assign accept   = (st == S_ACTIVE) && bus.data_valid
                    && !start;
  assign cnt_full = &cnt_r;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) st <= S_IDLE;
    else          st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      S_IDLE:   if (bus.finish) nxt = S_ERROR;
                else if (bus.go) nxt = S_ACTIVE;
      S_ACTIVE: if (bus.finish) nxt = S_DONE;
      S_DONE:   if (bus.finish) nxt = S_ERROR;
                else if (bus.go) nxt = S_ACTIVE;
      S_ERROR:  if (start) nxt = S_ACTIVE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.result_valid = (st == S_DONE);
    bus.debug_error  = (st == S_ERROR);
  end

  always_comb begin
    min_n = min_r;
    max_n = max_r;
    cnt_n = cnt_r;
    if (accept) begin
      if (cnt_r == '0) begin
        min_n = bus.data_in;
        max_n = bus.data_in;
      end else begin
        if (lt(bus.data_in, min_r)) min_n = bus.data_in;
        if (lt(max_r, bus.data_in)) max_n = bus.data_in;
      end
      if (!cnt_full) cnt_n = cnt_r + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      min_r   <= '0;
      max_r   <= '0;
      cnt_r   <= '0;
      sat_r   <= 1'b0;
      empty_r <= 1'b0;
      min_o   <= '0;
      max_o   <= '0;
      rng_o   <= '0;
      cnt_o   <= '0;
    end else begin
      if (start) begin
        cnt_r   <= '0;
        sat_r   <= 1'b0;
        empty_r <= 1'b0;
      end else if (accept) begin
        min_r <= min_n;
        max_r <= max_n;
        cnt_r <= cnt_n;
        if (cnt_full) sat_r <= 1'b1;
      end
      if (close) begin
        cnt_o <= cnt_n;
        if (cnt_n == '0) begin
          empty_r <= 1'b1;
          min_o   <= '0;
          max_o   <= '0;
          rng_o   <= '0;
        end else begin
          min_o <= min_n;
          max_o <= max_n;
          rng_o <= max_n - min_n;
        end
      end
    end
  end

  assign bus.min_out   = min_o;
  assign bus.max_out   = max_o;
  assign bus.range_out = rng_o;
  assign bus.count_out = cnt_o;
  assign bus.empty     = empty_r;
  assign bus.cnt_sat   = sat_r;

endmodule
